// File: rtl/dram_arbiter_if.sv
// Bus bundle between the I/D requesters, the arbiter and the SRAM controller.
// slave = arbiter side, master = requesters plus controller side.
interface dram_arbiter_if;
  logic        i_req;
  logic [2:0]  i_rd_ctrl;
  logic [63:0] i_addr;
  logic        i_gnt;
  logic        i_done;
  logic [63:0] i_rdata;

  logic        d_req;
  logic [2:0]  d_rd_ctrl;
  logic [2:0]  d_wr_ctrl;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_gnt;
  logic        d_done;
  logic [63:0] d_rdata;

  logic        err;
  logic        busy;
  logic        owner;

  logic [2:0]  ctl_rd_ctrl;
  logic [2:0]  ctl_wr_ctrl;
  logic [63:0] ctl_addr;
  logic [63:0] ctl_din;
  logic [63:0] ctl_dout;
  logic [1:0]  ctl_state;

  modport slave (
    input  i_req, i_rd_ctrl, i_addr,
    output i_gnt, i_done, i_rdata,
    input  d_req, d_rd_ctrl, d_wr_ctrl,
    input  d_addr, d_wdata,
    output d_gnt, d_done, d_rdata,
    output err, busy, owner,
    output ctl_rd_ctrl, ctl_wr_ctrl,
    output ctl_addr, ctl_din,
    input  ctl_dout, ctl_state
  );

  modport master (
    output i_req, i_rd_ctrl, i_addr,
    input  i_gnt, i_done, i_rdata,
    output d_req, d_rd_ctrl, d_wr_ctrl,
    output d_addr, d_wdata,
    input  d_gnt, d_done, d_rdata,
    input  err, busy, owner,
    input  ctl_rd_ctrl, ctl_wr_ctrl,
    input  ctl_addr, ctl_din,
    output ctl_dout, ctl_state
  );
endinterface

// File: rtl/dram_arbiter.sv
// Arbitrates I-fetch and D-mem ports onto one SRAM controller.
// D has priority with a starvation bound on I; a watchdog aborts hung accesses.
module dram_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 32
) (
  input logic            clk,
  input logic            rst_n,
  dram_arbiter_if.slave  bus
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam int WW = $clog2(TIMEOUT + 1);
  localparam logic [SW-1:0] S_MAX   = SW'(STARVE_MAX);
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic          owner_q;
  logic [2:0]    rd_q;
  logic [2:0]    wr_q;
  logic [63:0]   addr_q;
  logic [63:0]   din_q;
  logic [SW-1:0] starve_q;
  logic [WW-1:0] wd_q;
  logic          err_q;
  logic [63:0]   i_rdata_q;
  logic [63:0]   d_rdata_q;

  logic       idle;
  logic       d_win;
  logic       gnt_d;
  logic       gnt_i;
  logic       gnt_any;
  logic [2:0] req_rd;
  logic [2:0] req_wr;
  logic       req_noop;
  logic       ctl_busy;
  logic       in_acc;
  logic       wd_last;
  logic       abort;
  logic       cap;

  assign idle  = (state_q == IDLE);
  assign d_win = bus.d_req &&
                 (!bus.i_req || starve_q < S_MAX);
  // Gating with rst_n keeps gnt at 0 while reset is held.
  assign gnt_d   = rst_n && idle && d_win;
  assign gnt_i   = rst_n && idle && !d_win
                   && bus.i_req;
  assign gnt_any = gnt_d || gnt_i;

  assign req_wr = gnt_d ? bus.d_wr_ctrl : 3'd0;
  assign req_rd = gnt_d ?
                  ((bus.d_wr_ctrl != 3'd0) ?
                   3'd0 : bus.d_rd_ctrl) :
                  bus.i_rd_ctrl;
  assign req_noop = (req_rd == 3'd0) &&
                    (req_wr == 3'd0);

  assign ctl_busy = (bus.ctl_state != 2'b00);
  assign in_acc   = (state_q == ISSUE) ||
                    (state_q == WAIT);
  assign wd_last  = (wd_q == WD_LAST);
  // A WAIT that completes on its last budget cycle is a normal finish.
  assign abort = wd_last &&
                 ((state_q == ISSUE) ||
                  ((state_q == WAIT) && ctl_busy));
  assign cap   = (state_q == WAIT) && !ctl_busy;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (gnt_any)
          state_d = req_noop ? DONE : ISSUE;
      end
      ISSUE: begin
        if (abort)
          state_d = DONE;
        else if (ctl_busy)
          state_d = WAIT;
      end
      WAIT: begin
        if (cap || abort)
          state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      owner_q   <= 1'b0;
      rd_q      <= '0;
      wr_q      <= '0;
      addr_q    <= '0;
      din_q     <= '0;
      starve_q  <= '0;
      wd_q      <= '0;
      err_q     <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= abort;

      if (gnt_any) begin
        owner_q <= gnt_d;
        rd_q    <= req_rd;
        wr_q    <= req_wr;
        addr_q  <= gnt_d ? bus.d_addr : bus.i_addr;
        din_q   <= gnt_d ? bus.d_wdata : '0;
      end

      if (gnt_any && !req_noop)
        wd_q <= '0;
      else if (in_acc)
        wd_q <= wd_q + WW'(1);

      if (idle) begin
        if (gnt_i)
          starve_q <= '0;
        else if (gnt_d && bus.i_req) begin
          if (starve_q != S_MAX)
            starve_q <= starve_q + SW'(1);
        end else if (!bus.i_req)
          starve_q <= '0;
      end

      if (gnt_any && req_noop) begin
        if (gnt_d) d_rdata_q <= '0;
        else       i_rdata_q <= '0;
      end else if (abort) begin
        if (owner_q) d_rdata_q <= '0;
        else         i_rdata_q <= '0;
      end else if (cap) begin
        if (owner_q)
          d_rdata_q <= (rd_q != 3'd0) ?
                       bus.ctl_dout : '0;
        else
          i_rdata_q <= (rd_q != 3'd0) ?
                       bus.ctl_dout : '0;
      end
    end
  end

  assign bus.i_gnt   = gnt_i;
  assign bus.d_gnt   = gnt_d;
  assign bus.i_done  = (state_q == DONE) && !owner_q;
  assign bus.d_done  = (state_q == DONE) && owner_q;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.err     = (state_q == DONE) && err_q;
  assign bus.busy    = !idle;
  assign bus.owner   = owner_q;

  assign bus.ctl_rd_ctrl =
    ((state_q == ISSUE) && !abort) ? rd_q : 3'd0;
  assign bus.ctl_wr_ctrl =
    ((state_q == ISSUE) && !abort) ? wr_q : 3'd0;
  assign bus.ctl_addr = addr_q;
  assign bus.ctl_din  = din_q;

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus random single transactions
// checked against a transaction-level model of the arbiter and a simple controller.
module tb_dram_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  dram_arbiter_if bus();

  dram_arbiter #(
    .STARVE_MAX(4),
    .TIMEOUT(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  int vec = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: busy in the command cycle and L-1 cycles after it.
  int          lat = 4;
  logic [63:0] mdout = '0;
  bit          hang = 1'b0;
  int          rem = 0;
  bit          hang_seen = 1'b0;
  logic        ctl_cmd;

  assign ctl_cmd = (bus.ctl_rd_ctrl != 3'd0) ||
                   (bus.ctl_wr_ctrl != 3'd0);
  assign bus.ctl_state =
    (ctl_cmd || rem != 0 || hang_seen) ? 2'b01 : 2'b00;
  assign bus.ctl_dout = mdout;

  always @(posedge clk) begin
    if (ctl_cmd) begin
      rem <= lat - 1;
      if (hang) hang_seen <= 1'b1;
    end else if (rem > 0) begin
      rem <= rem - 1;
    end
    if (!hang) hang_seen <= 1'b0;
  end

  // Monitor: only this process writes these.
  int          n_ctrl = 0;
  int          last_ctrl = -1;
  int          done_cnt = 0;
  int          done_cyc = -1;
  int          both_gnt = 0;
  logic [2:0]  m_rd, m_wr;
  logic [63:0] m_addr, m_din, m_rdata;
  logic        m_port, m_err, m_busy_after;
  bit          prev_done = 1'b0;
  int          gq[$];

  always begin
    @(negedge clk);
    #2;
    if (bus.i_gnt && bus.d_gnt) both_gnt++;
    if (bus.i_gnt) gq.push_back(0);
    if (bus.d_gnt) gq.push_back(1);
    if (prev_done) m_busy_after = bus.busy;
    prev_done = bus.i_done || bus.d_done;
    if (ctl_cmd) begin
      n_ctrl++;
      last_ctrl = cyc;
      m_rd   = bus.ctl_rd_ctrl;
      m_wr   = bus.ctl_wr_ctrl;
      m_addr = bus.ctl_addr;
      m_din  = bus.ctl_din;
    end
    if (bus.i_done || bus.d_done) begin
      done_cnt++;
      done_cyc = cyc;
      m_port   = bus.d_done;
      m_rdata  = bus.d_done ? bus.d_rdata : bus.i_rdata;
      m_err    = bus.err;
    end
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    vec++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One request on one port; expectations come from the transaction rules.
  task automatic run_txn(input string tag, input bit is_d,
                         input logic [2:0] rd,
                         input logic [2:0] wr,
                         input logic [63:0] addr,
                         input logic [63:0] wd,
                         input logic [63:0] dout,
                         input int l, input bit hg);
    int b_ctrl, b_done, gc, exp_done;
    bit got, noop;
    logic [2:0] er, ew;
    logic [63:0] exp_rdata;
    er   = is_d ? ((wr != 3'd0) ? 3'd0 : rd) : rd;
    ew   = is_d ? wr : 3'd0;
    noop = (er == 3'd0) && (ew == 3'd0);
    if (noop)    exp_done = 1;
    else if (hg) exp_done = 1 + 32;
    else         exp_done = l + 2;
    exp_rdata = (noop || hg || ew != 3'd0) ? 64'd0 : dout;
    lat = l;
    mdout = dout;
    hang = hg;
    b_ctrl = n_ctrl;
    b_done = done_cnt;
    @(negedge clk);
    if (is_d) begin
      bus.d_req = 1'b1; bus.d_rd_ctrl = rd;
      bus.d_wr_ctrl = wr; bus.d_addr = addr;
      bus.d_wdata = wd;
    end else begin
      bus.i_req = 1'b1; bus.i_rd_ctrl = rd;
      bus.i_addr = addr;
    end
    got = 1'b0;
    gc = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (is_d ? bus.d_gnt : bus.i_gnt) begin
        got = 1'b1;
        gc = cyc;
        break;
      end
      @(negedge clk);
    end
    chk({tag, ":gnt"}, 64'(got), 64'd1);
    @(negedge clk);
    bus.d_req = 1'b0;
    bus.i_req = 1'b0;
    for (int k = 0; k < 60; k++) begin
      if (done_cnt != b_done) break;
      @(negedge clk);
      #3;
    end
    @(negedge clk);
    #3;
    hang = 1'b0;
    chk({tag, ":ndone"}, 64'(done_cnt - b_done), 64'd1);
    chk({tag, ":lat"}, 64'(done_cyc - gc),
        64'(exp_done));
    chk({tag, ":port"}, 64'(m_port), 64'(is_d));
    chk({tag, ":rdata"}, m_rdata, exp_rdata);
    chk({tag, ":err"}, 64'(m_err), 64'(hg && !noop));
    chk({tag, ":busy_after"}, 64'(m_busy_after), 64'd0);
    chk({tag, ":nctrl"}, 64'(n_ctrl - b_ctrl),
        noop ? 64'd0 : 64'd1);
    if (!noop) begin
      chk({tag, ":ctrl_cyc"}, 64'(last_ctrl - gc), 64'd1);
      chk({tag, ":ctl_rd"}, 64'(m_rd), 64'(er));
      chk({tag, ":ctl_wr"}, 64'(m_wr), 64'(ew));
      chk({tag, ":ctl_addr"}, m_addr, addr);
      chk({tag, ":ctl_din"}, m_din, is_d ? wd : 64'd0);
    end
    repeat (8) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout cyc=%0d required=finish", cyc);
    $fatal(1, "bench timeout");
  end

  initial begin
    int b, s, b_done;
    bit exp_d;
    bus.i_req = 0; bus.i_rd_ctrl = 0; bus.i_addr = 0;
    bus.d_req = 0; bus.d_rd_ctrl = 0; bus.d_wr_ctrl = 0;
    bus.d_addr = 0; bus.d_wdata = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst:busy", 64'(bus.busy), 64'd0);
    chk("rst:owner", 64'(bus.owner), 64'd0);
    chk("rst:done", 64'({bus.i_done, bus.d_done, bus.err}), 64'd0);
    chk("rst:ctl_addr", bus.ctl_addr, 64'd0);
    chk("rst:d_rdata", bus.d_rdata, 64'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    run_txn("t1_read", 1'b1, 3'd6, 3'd0, 64'h8000_0010, 64'd0,
            64'h1122334455667788, 4, 1'b0);
    run_txn("t2_write", 1'b1, 3'd0, 3'd4, 64'h8000_0020,
            64'hDEADBEEF_CAFEF00D, 64'h5555, 3, 1'b0);
    run_txn("t_minlat", 1'b0, 3'd2, 3'd0, 64'h40, 64'd0,
            64'hA5A5_0000_1234_5678, 1, 1'b0);
    run_txn("t4_timeout", 1'b1, 3'd3, 3'd0, 64'h100, 64'd0,
            64'hFFFF_FFFF_FFFF_FFFF, 4, 1'b1);
    run_txn("t5_noop", 1'b0, 3'd0, 3'd0, 64'h200, 64'd0,
            64'h77, 4, 1'b0);

    // Both ports held: expected order follows the starvation rule.
    lat = 1;
    b = gq.size();
    @(negedge clk);
    bus.d_req = 1; bus.d_rd_ctrl = 3'd1; bus.d_addr = 64'h300;
    bus.i_req = 1; bus.i_rd_ctrl = 3'd1; bus.i_addr = 64'h400;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      #3;
      if (gq.size() >= b + 10) break;
    end
    @(negedge clk);
    bus.d_req = 0;
    bus.i_req = 0;
    repeat (10) @(negedge clk);
    chk("t3_count", 64'(gq.size() - b >= 10), 64'd1);
    s = 0;
    for (int j = 0; j < 10; j++) begin
      exp_d = (s < 4);
      s = exp_d ? s + 1 : 0;
      if (gq.size() > b + j)
        chk($sformatf("t3_order%0d", j), 64'(gq[b + j]),
            64'(exp_d));
    end
    chk("t3_onegnt", 64'(both_gnt), 64'd0);

    // Reset in the middle of a WAIT.
    lat = 6;
    mdout = 64'h0BAD_F00D_0000_0001;
    @(negedge clk);
    bus.d_req = 1; bus.d_rd_ctrl = 3'd5; bus.d_wr_ctrl = 0;
    bus.d_addr = 64'h900; bus.d_wdata = 64'h1234;
    #1;
    @(negedge clk);
    bus.d_req = 0;
    repeat (2) @(negedge clk);
    b_done = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("t6_busy", 64'(bus.busy), 64'd0);
    chk("t6_owner", 64'(bus.owner), 64'd0);
    chk("t6_ctl_addr", bus.ctl_addr, 64'd0);
    chk("t6_ctl_din", bus.ctl_din, 64'd0);
    chk("t6_ctrl", 64'({bus.ctl_rd_ctrl, bus.ctl_wr_ctrl}), 64'd0);
    chk("t6_rdata", bus.d_rdata | bus.i_rdata, 64'd0);
    chk("t6_flags", 64'({bus.i_done, bus.d_done, bus.err,
                         bus.i_gnt, bus.d_gnt}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_nodone", 64'(done_cnt - b_done), 64'd0);
    run_txn("t6_after", 1'b1, 3'd6, 3'd0, 64'h8000_0010, 64'd0,
            64'h0102030405060708, 2, 1'b0);

    for (int n = 0; n < 24; n++) begin
      bit rd_d;
      logic [2:0] rr, ww;
      rd_d = 1'($urandom_range(0, 1));
      rr = 3'($urandom_range(0, 6));
      ww = (rd_d && $urandom_range(0, 2) == 0) ?
           3'($urandom_range(1, 4)) : 3'd0;
      run_txn($sformatf("rnd%0d", n), rd_d, rr, ww,
              {$urandom, $urandom}, {$urandom, $urandom},
              {$urandom, $urandom}, $urandom_range(1, 6), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
    $finish;
  end

endmodule
